jk_seq_driver: RTL and testbench
================================

# jk_seq_driver

Sequence driver for a single JK flip-flop. It takes a target bit pattern and works out the J/K excitation needed each step from the flip-flop's fed-back Q. It drives the pattern into the flip-flop and counts the steps where Q does not reach the target. It sits on the input side of a `jk_ff` instance, either as a self-checking driver for flip-flop bring-up or as an excitation generator inside larger sequential logic.

## Interface
Parameters:
- `LEN`, default 8: pattern length in steps; legal range 1..16.
- `ERR_W`, default 4: width of the mismatch counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  capture `pattern` into the internal pattern register.
- `pattern`  in  LEN  target sequence; bit i is the required Q after step i.
- `start`  in  1  begin a run.
- `q_fb`  in  1  Q output of the driven flip-flop.
- `j`  out  1  J excitation to the flip-flop.
- `k`  out  1  K excitation to the flip-flop.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `step`  out  4  index of the current step.
- `err_cnt`  out  ERR_W  number of mismatched steps, saturating.

## Operation
States:
- IDLE:
  - `start` -> DRIVE, with `step`=0 and `err_cnt` cleared.
- DRIVE, one cycle:
  - `j`/`k` are combinational from `q_fb` and `pattern[step]`:
    - target 1, Q=0 -> j=1, k=0
    - target 0, Q=1 -> j=0, k=1
    - target equal to Q -> j=0, k=0
  - Next state: CHECK.
- CHECK, one cycle:
  - Compare `q_fb` with `pattern[step]`; on mismatch, `err_cnt`+1, saturating at all-ones.
  - If `step`==LEN-1 -> DONE; else `step`+1 and back to DRIVE.
- DONE, one cycle:
  - `done`=1, then -> IDLE.
  - `err_cnt` and the final `step` hold until the next `start` or `reset`.

Output rules:
- `j`=`k`=0 in every state other than DRIVE; the flip-flop holds.
- The J=K=1 toggle combination is never generated.
- `busy`=1 in DRIVE and CHECK only.

Handshake and boundary rules:
- `load` is accepted only in IDLE or DONE; ignored while `busy`.
- `start` is accepted only in IDLE; ignored in DRIVE, CHECK and DONE.
- `load` and `start` in the same IDLE cycle: the new pattern is captured and the run uses it.
- Counter saturation: once `err_cnt` is all-ones, further mismatches leave it unchanged.
- `LEN`=1: a run is DRIVE, CHECK, DONE.
- `reset` has priority over all inputs, including mid-run. The run is abandoned and no `done` is produced.

## Timing
- Reset values: state IDLE, `j`=0, `k`=0, `busy`=0, `done`=0, `step`=0, `err_cnt`=0, pattern register all zero.
- `start` sampled at edge E0 -> DRIVE during the cycle after E0; `busy` rises at E0.
- The flip-flop latches `j`/`k` at the edge closing DRIVE. `q_fb` is compared at the edge closing CHECK, so one full cycle is allowed for the flip-flop to settle.
- Each step takes 2 cycles.
- `done` is high during cycle 2·LEN+1 after E0, and `busy` falls at the same edge `done` rises.
- A new `start` is accepted at the earliest in the first IDLE cycle after `done`, i.e. a minimum 2·LEN+2 cycles from start to start.
- `q_fb` is assumed registered in the flip-flop, so there is no combinational loop through `j`/`k`.

## Test plan
1. **Ideal flip-flop.** Pattern 8'b1010_0101 loaded, ideal `jk_ff` model starting at Q=0, `start` pulsed.
   - Step 0 drives j=1, k=0; step 1 drives j=0, k=1.
   - `done` pulses 17 cycles after `start`; `err_cnt`=0; flip-flop Q ends at 1 (bit 7).
2. **Stuck-at-0 feedback.** `q_fb` tied to 0, pattern 8'b1010_0101.
   - j=1, k=0 at each target-1 step; `err_cnt`=4 at `done`.
3. **Inverted feedback.** `q_fb` = ~Q of an ideal flip-flop, pattern 8'hFF.
   - `err_cnt`=8 at `done`.
   - Rerun with ERR_W=2: `err_cnt` saturates at 3.
4. **Reset mid-run.** `reset` asserted during the CHECK of step 3.
   - Next cycle: `busy`=0, `j`=`k`=0, `step`=0, `err_cnt`=0.
   - No `done` pulse; the following `start` runs a full 17 cycles.
5. **Inputs while busy.** `start` and `load` (pattern 8'h00) pulsed during step 2 of a run with 8'hFF.
   - Both are ignored; the run completes on 8'hFF with a single `done`.
6. **Same-cycle load and start.** `load` and `start` together in IDLE with pattern 8'h0F.
   - The run uses 8'h0F: step 0 drives j=1, k=0 from Q=0; step 4 drives j=0, k=1.
   - `err_cnt`=0 with the ideal flip-flop.

Source files
------------

// File: rtl/jk_seq_driver_if.sv
// Pattern/handshake and J/K excitation bundle between a sequence driver and its user.
// The driver connects through the slave modport.
interface jk_seq_driver_if #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned ERR_W = 4
);
  logic             load;
  logic [LEN-1:0]   pattern;
  logic             start;
  logic             q_fb;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic [3:0]       step;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output load, pattern, start, q_fb,
    input  j, k, busy, done, step, err_cnt
  );

  modport slave (
    input  load, pattern, start, q_fb,
    output j, k, busy, done, step, err_cnt
  );
endinterface

// File: rtl/jk_seq_driver.sv
// Drives a target bit pattern into a JK flip-flop one step at a time and
// counts (saturating) the steps where the fed-back Q misses its target.
module jk_seq_driver #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned ERR_W = 4
) (
  input logic             clk,
  input logic             reset,
  jk_seq_driver_if.slave  bus
);

  localparam int unsigned STEP_W = 4;
  localparam int unsigned PAT_W  = 16;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [PAT_W-1:0]  pat_q;
  logic [STEP_W-1:0] step_q;
  logic [ERR_W-1:0]  err_q;
  logic              busy_q;
  logic              done_q;
  logic              target;

  // Pattern is held zero-extended to 16 bits so the 4-bit step indexes it exactly.
  assign target = pat_q[step_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pat_q  <= '0;
      step_q <= '0;
      err_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            pat_q <= PAT_W'(bus.pattern);
          end
          if (bus.start) begin
            state  <= DRIVE;
            step_q <= '0;
            err_q  <= '0;
            busy_q <= 1'b1;
          end
        end
        DRIVE: begin
          state <= CHECK;
        end
        CHECK: begin
          if ((bus.q_fb != target) && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
          end
          if (step_q == LAST_STEP) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            step_q <= step_q + STEP_W'(1);
            state  <= DRIVE;
          end
        end
        DONE: begin
          if (bus.load) begin
            pat_q <= PAT_W'(bus.pattern);
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Excitation is set/reset/hold only; J and K are never both high.
  assign bus.j = (state == DRIVE) &&  target && !bus.q_fb;
  assign bus.k = (state == DRIVE) && !target &&  bus.q_fb;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.step    = step_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: table-driven runs plus random runs against a step-level
// excitation/mismatch model, with ideal, stuck-at-0, inverted and random feedback.
module tb_jk_seq_driver;

  localparam int LEN = 8;

  typedef struct {
    logic [7:0] pat;
    int         mode;   // 0 ideal FF, 1 stuck-at-0, 2 inverted FF, 3 random
    bit         same;   // load and start in the same cycle
    int         poke;   // run cycle in which start+load(8'h00) are pulsed, 0 = none
    bit         clr;    // clear the flip-flop models first
    int         exp_a;  // expected final err_cnt for ERR_W=4, -1 = model only
    int         exp_b;  // expected final err_cnt for ERR_W=2, -1 = model only
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ff_clr;
  logic q_a, q_b, q_c;
  logic rnd;
  int   fb_mode;
  int   n_cmp = 0;
  int   n_bad = 0;

  jk_seq_driver_if #(.LEN(8), .ERR_W(4)) bus_a ();
  jk_seq_driver_if #(.LEN(8), .ERR_W(2)) bus_b ();
  jk_seq_driver_if #(.LEN(1), .ERR_W(4)) bus_c ();

  jk_seq_driver #(.LEN(8), .ERR_W(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  jk_seq_driver #(.LEN(8), .ERR_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  jk_seq_driver #(.LEN(1), .ERR_W(4)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  always #5 clk = ~clk;

  assign bus_b.load    = bus_a.load;
  assign bus_b.pattern = bus_a.pattern;
  assign bus_b.start   = bus_a.start;

  function automatic logic fb(input int mode, input logic q, input logic r);
    case (mode)
      0:       return q;
      1:       return 1'b0;
      2:       return ~q;
      default: return r;
    endcase
  endfunction

  assign bus_a.q_fb = fb(fb_mode, q_a, rnd);
  assign bus_b.q_fb = fb(fb_mode, q_b, rnd);
  assign bus_c.q_fb = q_c;

  // Ideal jk_ff models, one per driver.
  always @(posedge clk) begin
    rnd <= 1'($urandom);
    if (ff_clr) begin
      q_a <= 1'b0;
      q_b <= 1'b0;
      q_c <= 1'b0;
    end else begin
      case ({bus_a.j, bus_a.k})
        2'b10: q_a <= 1'b1;
        2'b01: q_a <= 1'b0;
        2'b11: q_a <= ~q_a;
        default: ;
      endcase
      case ({bus_b.j, bus_b.k})
        2'b10: q_b <= 1'b1;
        2'b01: q_b <= 1'b0;
        2'b11: q_b <= ~q_b;
        default: ;
      endcase
      case ({bus_c.j, bus_c.k})
        2'b10: q_c <= 1'b1;
        2'b01: q_c <= 1'b0;
        2'b11: q_c <= ~q_c;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic j, input logic k, input logic busy,
                         input logic done, input logic [3:0] step, input int err,
                         input int ej, input int ek, input int ebusy, input int edone,
                         input int estep, input int eerr);
    chk({tag, " j"},    int'(j),    ej);
    chk({tag, " k"},    int'(k),    ek);
    chk({tag, " busy"}, int'(busy), ebusy);
    chk({tag, " done"}, int'(done), edone);
    chk({tag, " step"}, int'(step), estep);
    chk({tag, " err"},  err,        eerr);
  endtask

  // One full run on drivers a and b, checked every cycle against the step model.
  task automatic run(input vec_t v);
    int         ea, eb, i;
    int         ja, ka, jb, kb;
    bit         running, drv, cmp;
    logic [7:0] pat;
    string      tag;
    pat     = v.pat;
    fb_mode = v.mode;
    if (v.clr) begin
      ff_clr = 1'b1;
      @(negedge clk);
      ff_clr = 1'b0;
    end
    if (!v.same) begin
      bus_a.load    = 1'b1;
      bus_a.pattern = pat;
      @(negedge clk);
    end
    bus_a.load    = v.same;
    bus_a.pattern = pat;
    bus_a.start   = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.load  = 1'b0;
    ea = 0;
    eb = 0;
    for (int c = 1; c <= 2 * LEN + 1; c++) begin
      running = (c <= 2 * LEN);
      i       = running ? (c - 1) / 2 : LEN - 1;
      drv     = running && (c % 2 == 1);
      cmp     = running && (c % 2 == 0);
      ja = int'(drv &&  pat[3'(i)] && !bus_a.q_fb);
      ka = int'(drv && !pat[3'(i)] &&  bus_a.q_fb);
      jb = int'(drv &&  pat[3'(i)] && !bus_b.q_fb);
      kb = int'(drv && !pat[3'(i)] &&  bus_b.q_fb);
      tag = $sformatf("pat%02h m%0d c%0d", pat, v.mode, c);
      chk_out({tag, " a"}, bus_a.j, bus_a.k, bus_a.busy, bus_a.done, bus_a.step,
              int'(bus_a.err_cnt), ja, ka, int'(running), int'(c == 2 * LEN + 1), i, ea);
      chk_out({tag, " b"}, bus_b.j, bus_b.k, bus_b.busy, bus_b.done, bus_b.step,
              int'(bus_b.err_cnt), jb, kb, int'(running), int'(c == 2 * LEN + 1), i, eb);
      if (cmp) begin
        if (bus_a.q_fb != pat[3'(i)]) ea = (ea < 15) ? ea + 1 : ea;
        if (bus_b.q_fb != pat[3'(i)]) eb = (eb < 3) ? eb + 1 : eb;
      end
      if (c == 2 * LEN + 1) begin
        if (v.exp_a >= 0) chk({tag, " final err a"}, int'(bus_a.err_cnt), v.exp_a);
        if (v.exp_b >= 0) chk({tag, " final err b"}, int'(bus_b.err_cnt), v.exp_b);
      end
      if (v.poke != 0 && c == v.poke) begin
        bus_a.start   = 1'b1;
        bus_a.load    = 1'b1;
        bus_a.pattern = 8'h00;
      end else if (v.poke != 0 && c == v.poke + 1) begin
        bus_a.start   = 1'b0;
        bus_a.load    = 1'b0;
        bus_a.pattern = pat;
      end
      @(negedge clk);
    end
    tag = $sformatf("pat%02h m%0d idle", pat, v.mode);
    chk_out({tag, " a"}, bus_a.j, bus_a.k, bus_a.busy, bus_a.done, bus_a.step,
            int'(bus_a.err_cnt), 0, 0, 0, 0, LEN - 1, ea);
    chk_out({tag, " b"}, bus_b.j, bus_b.k, bus_b.busy, bus_b.done, bus_b.step,
            int'(bus_b.err_cnt), 0, 0, 0, 0, LEN - 1, eb);
    if (v.mode == 0) chk({tag, " ff q"}, int'(q_a), int'(pat[7]));
  endtask

  vec_t tbl[6];
  vec_t rv;
  bit   seen_done;

  initial begin
    tbl[0] = '{pat: 8'hA5, mode: 0, same: 1'b0, poke: 0, clr: 1'b1, exp_a: 0, exp_b: 0};
    tbl[1] = '{pat: 8'hFF, mode: 2, same: 1'b0, poke: 0, clr: 1'b0, exp_a: 8, exp_b: 3};
    tbl[2] = '{pat: 8'hA5, mode: 1, same: 1'b0, poke: 0, clr: 1'b0, exp_a: 4, exp_b: 3};
    tbl[3] = '{pat: 8'hFF, mode: 0, same: 1'b0, poke: 5, clr: 1'b1, exp_a: 0, exp_b: 0};
    tbl[4] = '{pat: 8'h0F, mode: 0, same: 1'b1, poke: 0, clr: 1'b1, exp_a: 0, exp_b: 0};
    tbl[5] = '{pat: 8'h00, mode: 1, same: 1'b0, poke: 0, clr: 1'b0, exp_a: 0, exp_b: 0};

    reset         = 1'b1;
    ff_clr        = 1'b1;
    fb_mode       = 0;
    bus_a.load    = 1'b0;
    bus_a.start   = 1'b0;
    bus_a.pattern = '0;
    bus_c.load    = 1'b0;
    bus_c.start   = 1'b0;
    bus_c.pattern = '0;
    repeat (2) @(negedge clk);
    chk_out("reset a", bus_a.j, bus_a.k, bus_a.busy, bus_a.done, bus_a.step,
            int'(bus_a.err_cnt), 0, 0, 0, 0, 0, 0);
    chk_out("reset c", bus_c.j, bus_c.k, bus_c.busy, bus_c.done, bus_c.step,
            int'(bus_c.err_cnt), 0, 0, 0, 0, 0, 0);
    reset  = 1'b0;
    ff_clr = 1'b0;
    @(negedge clk);

    foreach (tbl[n]) run(tbl[n]);

    // Reset during the CHECK of step 3 abandons the run without a done pulse.
    fb_mode = 0;
    ff_clr  = 1'b1;
    bus_a.load    = 1'b1;
    bus_a.pattern = 8'hA5;
    @(negedge clk);
    ff_clr      = 1'b0;
    bus_a.load  = 1'b0;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort pre busy", int'(bus_a.busy), 1);
    chk("abort pre step", int'(bus_a.step), 3);
    reset = 1'b1;
    @(negedge clk);
    chk_out("abort a", bus_a.j, bus_a.k, bus_a.busy, bus_a.done, bus_a.step,
            int'(bus_a.err_cnt), 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus_a.done || bus_a.busy) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("abort no done", int'(seen_done), 0);
    run('{pat: 8'hA5, mode: 0, same: 1'b0, poke: 0, clr: 1'b0, exp_a: 0, exp_b: 0});

    // Random patterns and feedback against the step model.
    for (int r = 0; r < 16; r++) begin
      rv.pat   = 8'($urandom);
      rv.mode  = int'($urandom_range(0, 3));
      rv.same  = 1'($urandom);
      rv.poke  = 0;
      rv.clr   = 1'($urandom);
      rv.exp_a = -1;
      rv.exp_b = -1;
      run(rv);
    end

    // LEN=1: DRIVE, CHECK, DONE.
    ff_clr        = 1'b1;
    bus_c.load    = 1'b1;
    bus_c.pattern = 1'b1;
    @(negedge clk);
    ff_clr      = 1'b0;
    bus_c.load  = 1'b0;
    bus_c.start = 1'b1;
    @(negedge clk);
    bus_c.start = 1'b0;
    chk_out("len1 set c1", bus_c.j, bus_c.k, bus_c.busy, bus_c.done, bus_c.step,
            int'(bus_c.err_cnt), 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk_out("len1 set c2", bus_c.j, bus_c.k, bus_c.busy, bus_c.done, bus_c.step,
            int'(bus_c.err_cnt), 0, 0, 1, 0, 0, 0);
    chk("len1 set q", int'(q_c), 1);
    @(negedge clk);
    chk_out("len1 set c3", bus_c.j, bus_c.k, bus_c.busy, bus_c.done, bus_c.step,
            int'(bus_c.err_cnt), 0, 0, 0, 1, 0, 0);
    bus_c.load    = 1'b1;
    bus_c.pattern = 1'b0;
    @(negedge clk);
    chk("len1 idle done", int'(bus_c.done), 0);
    bus_c.load  = 1'b0;
    bus_c.start = 1'b1;
    @(negedge clk);
    bus_c.start = 1'b0;
    chk_out("len1 clr c1", bus_c.j, bus_c.k, bus_c.busy, bus_c.done, bus_c.step,
            int'(bus_c.err_cnt), 0, 1, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_out("len1 clr c3", bus_c.j, bus_c.k, bus_c.busy, bus_c.done, bus_c.step,
            int'(bus_c.err_cnt), 0, 0, 0, 1, 0, 0);
    chk("len1 clr q", int'(q_c), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
